// File: rtl/lru8_victim_alloc.sv
// lru8_victim_alloc: per-set true-LRU age store for an 8-way array.
// Each set keeps one age per way, and the ages always form a permutation of 0..WAYS-1.
// Age 0 is MRU and age WAYS-1 is LRU. Hits touch a way. Victim requests pick
// the lowest invalid way (or the LRU way) and touch it in the same cycle.
//
// Handshake: a request transfers on a clock edge where req_valid & req_ready.
// A result transfers on an edge where vic_valid & vic_ready. vic_* hold steady
// while vic_valid & ~vic_ready. req_ready = RUN & (~vic_valid | vic_ready),
// which allows one request per cycle when the consumer is always ready.
module lru8_victim_alloc #(
    parameter int WAYS_LOG = 3,
    parameter int SETS_LOG = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hit_en,
    input  logic [SETS_LOG-1:0]        hit_set,
    input  logic [WAYS_LOG-1:0]        hit_way,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SETS_LOG-1:0]        req_set,
    input  logic [(1<<WAYS_LOG)-1:0]   req_inval,
    output logic                       vic_valid,
    input  logic                       vic_ready,
    output logic [WAYS_LOG-1:0]        vic_way,
    output logic [SETS_LOG-1:0]        vic_set,
    output logic                       init_busy
);

    localparam int WAYS  = 1 << WAYS_LOG;
    localparam int NSETS = 1 << SETS_LOG;

    typedef logic [WAYS_LOG-1:0] age_t;
    typedef logic [WAYS-1:0][WAYS_LOG-1:0] set_ages_t;
    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state_q;
    logic [SETS_LOG-1:0] init_cnt_q;
    logic                vic_valid_q;
    logic [WAYS_LOG-1:0] vic_way_q;
    logic [SETS_LOG-1:0] vic_set_q;

    set_ages_t ages_q [NSETS];
    set_ages_t ages_d [NSETS];

    logic      run;
    logic      hit_act;
    logic      req_fire;
    set_ages_t req_base;
    set_ages_t ident;
    age_t      victim;

    // Touched way becomes MRU; every way younger than it ages by one.
    // Ages only increment when below the touched age, so nothing can wrap.
    function automatic set_ages_t touch(input set_ages_t cur, input age_t way);
        set_ages_t nxt;
        age_t      a;
        a   = cur[way];
        nxt = cur;
        for (int k = 0; k < WAYS; k++) begin
            if (cur[k] < a) begin
                nxt[k] = cur[k] + age_t'(1);
            end
        end
        nxt[way] = '0;
        return nxt;
    endfunction

    assign run       = (state_q == S_RUN);
    assign req_ready = run & (~vic_valid_q | vic_ready);
    assign hit_act   = run & hit_en;
    assign req_fire  = req_valid & req_ready;
    assign init_busy = (state_q == S_INIT);
    assign vic_valid = vic_valid_q;
    assign vic_way   = vic_way_q;
    assign vic_set   = vic_set_q;

    // Victim selection uses the request set's ages after any same-cycle hit to that set.
    always_comb begin
        req_base = ages_q[req_set];
        if (hit_act && (hit_set == req_set)) begin
            req_base = touch(ages_q[hit_set], hit_way);
        end
        victim = '0;
        if (|req_inval) begin
            // Scan downward so the lowest-index invalid way wins.
            for (int k = WAYS - 1; k >= 0; k--) begin
                if (req_inval[k]) begin
                    victim = age_t'(k);
                end
            end
        end else begin
            for (int k = 0; k < WAYS; k++) begin
                if (req_base[k] == age_t'(WAYS - 1)) begin
                    victim = age_t'(k);
                end
            end
        end
    end

    // Next ages: the init pattern during INIT; otherwise the hit touch, then the allocation touch.
    always_comb begin
        for (int k = 0; k < WAYS; k++) begin
            ident[k] = age_t'(k);
        end
        for (int s = 0; s < NSETS; s++) begin
            ages_d[s] = ages_q[s];
        end
        if (!run) begin
            ages_d[init_cnt_q] = ident;
        end else begin
            if (hit_act) begin
                ages_d[hit_set] = touch(ages_q[hit_set], hit_way);
            end
            // For a same-set hit, req_base already includes the hit, so this write supersedes it.
            if (req_fire) begin
                ages_d[req_set] = touch(req_base, victim);
            end
        end
    end

    // Age storage. INIT rewrites every set after reset, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NSETS; s++) begin
                ages_q[s] <= ages_d[s];
            end
        end
    end

    // INIT/RUN control FSM with the registered victim result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            vic_valid_q <= 1'b0;
            vic_way_q   <= '0;
            vic_set_q   <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    init_cnt_q <= init_cnt_q + SETS_LOG'(1);
                    if (init_cnt_q == SETS_LOG'(NSETS - 1)) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (req_fire) begin
                        vic_valid_q <= 1'b1;
                        vic_way_q   <= victim;
                        vic_set_q   <= req_set;
                    end else if (vic_ready) begin
                        vic_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lru8_victim_alloc.sv
// tb_lru8_victim_alloc: randomized and directed stimulus against a recency-list model.
// The model keeps each set as an ordered list of ways (MRU first, LRU last).
// Expected victims are queued when a request is accepted, and a monitor checks them.
module tb_lru8_victim_alloc;

    localparam int WAYS_LOG = 3;
    localparam int SETS_LOG = 4;
    localparam int WAYS     = 1 << WAYS_LOG;
    localparam int NSETS    = 1 << SETS_LOG;
    localparam int RW       = SETS_LOG + WAYS_LOG;

    // ---------------- clock / reset / DUT ----------------
    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                hit_en = 1'b0;
    logic [SETS_LOG-1:0] hit_set = '0;
    logic [WAYS_LOG-1:0] hit_way = '0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [SETS_LOG-1:0] req_set = '0;
    logic [WAYS-1:0]     req_inval = '0;
    logic                vic_valid;
    logic                vic_ready = 1'b0;
    logic [WAYS_LOG-1:0] vic_way;
    logic [SETS_LOG-1:0] vic_set;
    logic                init_busy;

    always #5 clk = ~clk;

    lru8_victim_alloc #(.WAYS_LOG(WAYS_LOG), .SETS_LOG(SETS_LOG)) dut (
        .clk       (clk),
        .rst       (rst),
        .hit_en    (hit_en),
        .hit_set   (hit_set),
        .hit_way   (hit_way),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_set   (req_set),
        .req_inval (req_inval),
        .vic_valid (vic_valid),
        .vic_ready (vic_ready),
        .vic_way   (vic_way),
        .vic_set   (vic_set),
        .init_busy (init_busy)
    );

    // ---------------- reference model ----------------
    int ord [NSETS][WAYS];           // ord[s][r] = way with recency rank r (0 = MRU)
    logic [RW-1:0] exp_q[$];         // expected {set, way} results in order
    int  checks = 0;
    int  failures = 0;
    bit  mon_en = 1'b0;

    function automatic void model_reset();
        for (int s = 0; s < NSETS; s++)
            for (int r = 0; r < WAYS; r++)
                ord[s][r] = r;
    endfunction

    function automatic void model_touch(input int s, input int w);
        int p;
        p = 0;
        for (int r = 0; r < WAYS; r++)
            if (ord[s][r] == w) p = r;
        for (int r = p; r > 0; r--)
            ord[s][r] = ord[s][r-1];
        ord[s][0] = w;
    endfunction

    function automatic int model_victim(input int s, input logic [WAYS-1:0] inval);
        if (inval != '0) begin
            for (int k = 0; k < WAYS; k++)
                if (inval[k]) return k;
        end
        return ord[s][WAYS-1];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en && vic_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL vic_unexpected: got set=%0d way=%0d expected no result", vic_set, vic_way);
            end else begin
                check("vic_result", int'({vic_set, vic_way}), int'(exp_q[0]));
                if (vic_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic reset_dut(input bit full);
        int n;
        bit ready_low_ok;
        rst = 1'b1;
        req_valid = 1'b0;
        hit_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        mon_en = 1'b1;
        if (full) begin
            // Hits during INIT must be ignored; set 2 is later checked on that basis.
            hit_en = 1'b1; hit_set = 4'd2; hit_way = 3'd7;
        end
        @(negedge clk);
        check("rst_vic_valid", int'(vic_valid), 0);
        check("rst_init_busy", int'(init_busy), 1);
        check("rst_req_ready", int'(req_ready), 0);
        if (full) begin
            n = 1;
            ready_low_ok = 1'b1;
            while (n < 64) begin
                @(negedge clk);
                if (!init_busy) break;
                n++;
                if (req_ready) ready_low_ok = 1'b0;
            end
            hit_en = 1'b0;
            check("init_cycles", n, NSETS);
            check("init_ready_low", int'(ready_low_ok), 1);
            check("run_req_ready", int'(req_ready), 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic touch_only(input int s, input int w);
        hit_en = 1'b1; hit_set = SETS_LOG'(s); hit_way = WAYS_LOG'(w);
        model_touch(s, w);
        @(posedge clk); #1;
        hit_en = 1'b0;
    endtask

    // Holds the request until accepted; raises vic_ready after 3 stalled cycles.
    task automatic issue(input int s, input logic [WAYS-1:0] inval, input bit wh,
                         input int hs, input int hw, output int stalls);
        int v;
        req_valid = 1'b1; req_set = SETS_LOG'(s); req_inval = inval;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (req_ready || stalls >= 200) break;
            stalls++;
            if (stalls == 3) begin
                @(posedge clk); #1;
                vic_ready = 1'b1;
            end
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_timeout: got req_ready=0 expected 1 for set %0d", s);
            req_valid = 1'b0;
            return;
        end
        if (wh) begin
            hit_en = 1'b1; hit_set = SETS_LOG'(hs); hit_way = WAYS_LOG'(hw);
            model_touch(hs, hw);
        end
        v = model_victim(s, inval);
        model_touch(s, v);
        exp_q.push_back(RW'(s * WAYS + v));
        @(posedge clk); #1;
        req_valid = 1'b0;
        hit_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        vic_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic random_ops(input int count);
        int st, op, s;
        logic [WAYS-1:0] inval;
        for (int i = 0; i < count; i++) begin
            vic_ready = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 3);
            s = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, NSETS - 1);
            if (op == 0) begin
                touch_only(s, $urandom_range(0, WAYS - 1));
            end else if (op == 3) begin
                @(posedge clk); #1;
            end else begin
                inval = ($urandom_range(0, 3) == 0) ? WAYS'($urandom_range(1, 255)) : '0;
                issue(s, inval, bit'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) == 0) ? s : $urandom_range(0, NSETS - 1),
                      $urandom_range(0, WAYS - 1), st);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int st;
        repeat (2) @(posedge clk);
        #1;
        reset_dut(1'b1);
        vic_ready = 1'b1;

        // Fresh set 5: LRU is way 7, then ways 6..0 in turn.
        for (int i = 0; i < 8; i++) issue(5, '0, 1'b0, 0, 0, st);

        // Hit aging on set 2, then allocate.
        touch_only(2, 3);
        issue(2, '0, 1'b0, 0, 0, st);
        issue(2, '0, 1'b0, 0, 0, st);

        // Invalid preference on set 1.
        issue(1, 8'b0010_0100, 1'b0, 0, 0, st);
        issue(1, '0, 1'b0, 0, 0, st);

        // Same-cycle hit and request on set 0.
        issue(0, '0, 1'b1, 0, 7, st);
        for (int i = 0; i < 7; i++) issue(0, '0, 1'b0, 0, 0, st);

        // Backpressure: the second request stalls until vic_ready rises.
        drain();
        vic_ready = 1'b0;
        issue(3, '0, 1'b0, 0, 0, st);
        check("first_no_stall", st, 0);
        issue(3, '0, 1'b0, 0, 0, st);
        check("second_stall_cycles", st, 3);

        // Back-to-back throughput on set 9.
        vic_ready = 1'b1;
        for (int i = 0; i < 8; i++) issue(9, '0, 1'b0, 0, 0, st);

        random_ops(400);
        drain();

        // Reset with a result pending, then again partway through INIT.
        vic_ready = 1'b0;
        issue(6, '0, 1'b0, 0, 0, st);
        reset_dut(1'b0);
        repeat (6) @(posedge clk);
        #1;
        reset_dut(1'b1);

        vic_ready = 1'b1;
        for (int i = 0; i < 8; i++) issue(4, '0, 1'b0, 0, 0, st);
        random_ops(150);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lru8_victim_alloc.md
Name: lru8_victim_alloc

Overview:
- Owns the per-set true-LRU age state for an 8-way set-associative array and answers replacement requests with the way to evict.
- It is the consumer of the age-update rule: hits update ages, and allocations read ages, pick the victim and age it to MRU.
- It sits beside the cache tag array. The miss/fill controller issues victim requests; the tag pipeline issues hit touches.

Parameters:
- WAYS_LOG, 3, log2 of the way count. Age width is WAYS_LOG. WAYS=1<<WAYS_LOG.
- SETS_LOG, 4, log2 of the set count. NSETS=1<<SETS_LOG.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hit_en  in  1  touch request, one cycle
- hit_set  in  SETS_LOG  set touched
- hit_way  in  WAYS_LOG  way touched
- req_valid  in  1  victim request
- req_ready  out  1  request accepted when req_valid&req_ready
- req_set  in  SETS_LOG  set needing a victim
- req_inval  in  WAYS  per-way invalid mask for req_set (1=invalid)
- vic_valid  out  1  victim result valid
- vic_ready  in  1  consumer accepts result
- vic_way  out  WAYS_LOG  chosen way
- vic_set  out  SETS_LOG  set of the result
- init_busy  out  1  high while the age array is initialising

Behaviour:
- Storage: NSETS x WAYS ages of WAYS_LOG bits each, registers. Invariant: in every set the ages form a permutation of 0..WAYS-1. Age 0 is MRU; age WAYS-1 is LRU.
- Touch rule for way w with age a:
  - w becomes 0.
  - Ways with age < a get +1.
  - Ways with age > a are unchanged.
  - Touching a way with age 0 leaves the set unchanged.
- Reset/init FSM with states INIT and RUN:
  - rst forces INIT and sets init_cnt=0, vic_valid=0, vic_way=0, vic_set=0, req_ready=0, init_busy=1.
  - In INIT, each cycle writes set init_cnt with age[k]=k for all ways k, then increments init_cnt.
  - After set NSETS-1 is written, the FSM enters RUN on the next edge. This takes NSETS cycles, so 16 at the defaults.
  - In INIT, hit_en is ignored and req_ready=0.
  - rst asserted in RUN or mid-INIT restarts INIT from set 0 and drops any pending vic_valid.
- RUN:
  - req_ready = ~vic_valid | vic_ready.
  - hit_en is always applied. There is no backpressure on touches.
- Victim selection, evaluated combinationally in the accept cycle T:
  - If req_inval != 0, the victim is the lowest-index invalid way.
  - Otherwise the victim is the unique way with age WAYS-1.
  - The victim is then touched, with the update written at the end of T.
  - vic_valid, vic_way and vic_set are registered and appear at T+1.
  - The result holds stable while vic_valid & ~vic_ready.
  - vic_valid clears on handshake unless a new request is accepted in the same cycle, which allows back-to-back throughput of one per cycle.
- Simultaneous hit and request:
  - Same set: apply the hit touch first. Victim selection then uses the post-hit ages, and the allocation touch is applied on top. Both updates commit in the same edge.
  - Different sets: both updates commit independently.
  - A hit to the way chosen as victim in the same cycle yields the victim from the post-hit ages. That way is now MRU, so it is never selected unless it is invalid.
- Invalid-mask victim: the chosen invalid way is touched, so its age becomes 0 exactly as for an LRU victim.
- No arithmetic wrap is possible: increments apply only to ages < a ≤ WAYS-1.

Test Plan:
- Init: pulse rst for 1 cycle. Required: init_busy=1 for 16 cycles then 0; req_ready rises with it. Request set 5 with inval=0 → vic_way=7 at T+1, after which set 5 ages are way7=0 and ways 0..6 = 1..7.
- Hit aging: on fresh set 2, hit way 3 (age 3) → ages become w0=1, w1=2, w2=3, w3=0, w4..7 unchanged. A following request on set 2 → vic_way=7.
- Invalid preference: request set 1 with req_inval=8'b0010_0100 → vic_way=2 and way 2's age becomes 0.
- Same-cycle conflict: on fresh set 0, assert hit_en (set 0, way 7) together with req (set 0, inval=0) → vic_way=6. Afterwards way 6=0, way 7=1, and the permutation invariant holds.
- Backpressure: with vic_ready=0, issue two requests → the second is stalled (req_ready=0) and vic_way stays stable. Raise vic_ready → the second result appears the next cycle. Throughput: 8 back-to-back requests on set 9 with vic_ready=1 → vic_way sequence 7,6,5,4,3,2,1,0.
- Reset mid-operation: assert rst while vic_valid=1 and init at set 7 → vic_valid=0 next cycle, init restarts at set 0, and the full 16-cycle init is observed.
